// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
// Read-side master for the 8-bit synchronous FIFO. It issues read strobes while
// there is room for the byte to land. It captures the FIFO's registered
// data_out one clock after each accepted read into a small skid buffer. It
// re-presents the bytes downstream as a valid/ready stream in FIFO order, at up
// to one byte per clock.
//
// Ports
//   clk         in   clock, all logic on the rising edge
//   rst         in   synchronous, active-high reset
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO data_out, valid 1 clk after an accepted read
//   fifo_rd     out  read strobe to the FIFO (combinational)
//   m_valid     out  head byte valid downstream
//   m_data      out  head byte
//   m_ready     in   downstream accepts the head byte
//   occupancy   out  bytes currently held in the skid buffer
//   xfer_count  out  bytes delivered downstream, wraps silently
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int DATA_W     = 8,
    parameter int SKID_DEPTH = 2,   // power of 2, >= 2
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fifo_empty,
    input  logic [DATA_W-1:0]             fifo_data,
    output logic                          fifo_rd,
    output logic                          m_valid,
    output logic [DATA_W-1:0]             m_data,
    input  logic                          m_ready,
    output logic [$clog2(SKID_DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]              xfer_count
);

    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int LVL_W = PTR_W + 2;   // room for occupancy + inflight without overflow

    logic [DATA_W-1:0] r_skid [SKID_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_occ;
    logic              r_inflight;      // a read was accepted last clock; its byte arrives now
    logic [CNT_W-1:0]  r_xfer;

    logic              w_pop;
    logic [LVL_W-1:0]  w_held;          // bytes held plus the one on its way
    logic [LVL_W-1:0]  w_level;         // commitment left after this clock's pop

    assign w_pop   = (r_occ != '0) && m_ready;
    assign w_held  = {1'b0, r_occ} + LVL_W'(r_inflight);
    assign w_level = w_held - LVL_W'(w_pop);

    // The pop term lets a slot freed this clock be refilled in the same clock,
    // which is what sustains one byte per clock with only SKID_DEPTH entries.
    assign fifo_rd = !rst && !fifo_empty && (w_level < LVL_W'(SKID_DEPTH));

    assign m_valid    = (r_occ != '0);
    // The head is read straight from the registered array, so a byte captured
    // this edge only becomes visible on the next clock (no bypass path).
    assign m_data     = r_skid[r_rd_ptr];
    assign occupancy  = r_occ;
    assign xfer_count = r_xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the skid entries are reset too. m_data is read directly
            // from the array, so clearing it is what makes m_data read 0
            // after reset. The array is only SKID_DEPTH entries deep.
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_skid[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_xfer     <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignments. Each
            // update therefore sees the pre-edge values of r_occ,
            // r_inflight and the pointers, whatever order the lines are in.
            r_inflight <= fifo_rd;

            if (r_inflight) begin
                r_skid[r_wr_ptr] <= fifo_data;
                r_wr_ptr         <= r_wr_ptr + 1'b1;   // wraps: depth is a power of 2
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_xfer   <= r_xfer + 1'b1;
            end

            case ({r_inflight, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;              // capture and pop cancel out
            endcase
        end
    end

    // A byte must never be fetched without a free slot waiting for it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (w_held <= LVL_W'(SKID_DEPTH));
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
// Bench for fifo_stream_reader. A queue-based FIFO model feeds the reader. Every
// byte written to the FIFO is pushed into an expected-order queue. A monitor on
// the falling edge pops that queue whenever a handshake is presented. It also
// checks the counters and stream invariants against simple bench-side counts.
// A second instance with a 4-bit counter shares all inputs to exercise wrap.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

    localparam int DATA_W = 8;
    localparam int SKID   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fifo_empty = 1'b1;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              m_ready = 1'b0;

    logic              fifo_rd;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        occupancy;
    logic [15:0]       xfer_count;

    logic              fifo_rd4;
    logic              m_valid4;
    logic [DATA_W-1:0] m_data4;
    logic [1:0]        occupancy4;
    logic [3:0]        xfer_count4;

    fifo_stream_reader #(.DATA_W(DATA_W), .SKID_DEPTH(SKID), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(fifo_rd), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .occupancy(occupancy), .xfer_count(xfer_count)
    );

    fifo_stream_reader #(.DATA_W(DATA_W), .SKID_DEPTH(SKID), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(fifo_rd4), .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready),
        .occupancy(occupancy4), .xfer_count(xfer_count4)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- FIFO model ----------------
    logic [DATA_W-1:0] fifo_q[$];   // contents of the FIFO
    logic [DATA_W-1:0] wr_q[$];     // writes requested this clock
    logic [DATA_W-1:0] exp_q[$];    // scoreboard: bytes in expected delivery order
    bit                fifo_clr = 1'b0;

    always @(posedge clk) begin
        if (fifo_clr) begin
            fifo_q.delete();
        end else if (fifo_rd) begin
            if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
            else                   fifo_data <= 8'hEE;
        end
        while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic push_byte(input logic [DATA_W-1:0] b);
        wr_q.push_back(b);
        exp_q.push_back(b);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic              rst_at_edge = 1'b0;
    int                model_cnt   = 0;
    int                rd_pulses   = 0;
    int                pops_total  = 0;
    logic              prev_rd     = 1'b0;
    logic              prev_hold   = 1'b0;
    logic [DATA_W-1:0] prev_data   = '0;

    always @(posedge clk) rst_at_edge <= rst;

    always @(negedge clk) begin
        if (rst_at_edge) begin
            check("rst_m_valid",    m_valid,     0);
            check("rst_occupancy",  occupancy,   0);
            check("rst_xfer_count", xfer_count,  0);
            check("rst_m_data",     m_data,      0);
            check("rst_xfer4",      xfer_count4, 0);
            model_cnt = 0;
            prev_rd   = 1'b0;
            prev_hold = 1'b0;
        end
        if (rst) begin
            check("rst_fifo_rd", fifo_rd, 0);
            prev_rd   = 1'b0;
            prev_hold = 1'b0;
        end else begin
            check("rd_while_empty", fifo_rd && fifo_empty, 0);
            // inflight this clock is simply whether a read was issued last clock
            check("occ_plus_inflight", (int'(occupancy) + int'(prev_rd)) <= SKID, 1);
            check("xfer_count", xfer_count, model_cnt % 65536);
            check("xfer_count4", xfer_count4, model_cnt % 16);
            if (prev_hold) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("unexpected_byte", m_data, 32'hFFFF_FFFF);
                else                   check("stream_data", m_data, exp_q.pop_front());
                model_cnt++;
                pops_total++;
            end
            if (fifo_rd) rd_pulses++;
            prev_rd   = fifo_rd;
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || wr_q.size() != 0) && n < max_cycles) begin
            tick();
            n++;
        end
        check(name, n >= max_cycles, 0);
    endtask

    initial begin
        int first_rd, first_v, last_v, vcount;
        int rd_before, pops_before, pushed, n;

        // Reset held for 3 clocks while the FIFO holds 5 bytes.
        for (int i = 0; i < 5; i++) push_byte(8'($urandom));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_fifo_rd", fifo_rd, 0);
            check("reset_m_valid", m_valid, 0);
            check("reset_occupancy", occupancy, 0);
            check("reset_xfer_count", xfer_count, 0);
        end
        rst = 1'b0;
        m_ready = 1'b1;
        drain("drain_after_reset", 50);

        // Streaming 0x01..0x10 with m_ready held high.
        for (int i = 1; i <= 16; i++) push_byte(8'(i));
        first_rd = -1; first_v = -1; last_v = -1; vcount = 0;
        for (int c = 0; c < 40; c++) begin
            if (fifo_rd && first_rd < 0) first_rd = c;
            if (m_valid) begin
                if (first_v < 0) first_v = c;
                check("stream_seq", m_data, c - first_v + 1);
                last_v = c;
                vcount++;
            end
            tick();
        end
        check("stream_latency", first_v - first_rd, 2);
        check("stream_count", vcount, 16);
        check("stream_back_to_back", last_v - first_v, 15);
        check("stream_xfer", xfer_count, 21);

        // Backpressure: 8 bytes, downstream stalled for 10 clocks.
        m_ready = 1'b0;
        rd_before = rd_pulses;
        for (int i = 0; i < 8; i++) push_byte(8'hA0 + 8'(i));
        for (int i = 0; i < 10; i++) tick();
        check("bp_rd_pulses", rd_pulses - rd_before, 2);
        check("bp_occupancy", occupancy, 2);
        check("bp_m_valid", m_valid, 1);
        check("bp_m_data", m_data, 8'hA0);
        m_ready = 1'b1;
        drain("bp_drain", 40);
        check("bp_xfer", xfer_count, 29);

        // Random downstream readiness and random FIFO writes, 200 bytes.
        pushed = 0;
        n = 0;
        while ((pushed < 200 || exp_q.size() != 0) && n < 3000) begin
            m_ready = 1'($urandom_range(0, 1));
            if (pushed < 200 && $urandom_range(0, 1) == 1) begin
                push_byte(8'($urandom));
                pushed++;
            end
            tick();
            n++;
        end
        check("random_timeout", n >= 3000, 0);
        m_ready = 1'b1;
        drain("random_drain", 20);
        check("random_xfer", xfer_count, 229);

        // Single byte into an empty FIFO.
        rd_before   = rd_pulses;
        pops_before = pops_total;
        push_byte(8'h5A);
        for (int i = 0; i < 8; i++) tick();
        check("single_rd_pulses", rd_pulses - rd_before, 1);
        check("single_pops", pops_total - pops_before, 1);
        check("single_m_valid_after", m_valid, 0);
        check("single_fifo_rd_after", fifo_rd, 0);

        // Reset mid-transfer. Occupancy plus inflight never exceeds 2. So the
        // fullest state with a read still pending is one byte held plus one
        // byte in flight.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
        for (int i = 0; i < 3; i++) tick();
        check("mid_occupancy", occupancy, 1);
        check("mid_fifo_rd", fifo_rd, 0);
        rst = 1'b1;
        fifo_clr = 1'b1;
        exp_q.delete();
        tick();
        fifo_clr = 1'b0;
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_occupancy", occupancy, 0);
        check("mid_rst_xfer", xfer_count, 0);
        check("mid_rst_m_data", m_data, 0);
        check("mid_rst_fifo_rd", fifo_rd, 0);
        rst = 1'b0;
        m_ready = 1'b1;
        push_byte(8'h11);
        push_byte(8'h22);
        for (int i = 0; i < 15; i++) push_byte(8'($urandom));
        drain("post_rst_drain", 60);
        check("post_rst_xfer", xfer_count, 17);
        check("wrap_xfer4", xfer_count4, 1);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
